// File: rtl/texture_pkg.sv
// ============================================================================
//  Module   : texture_pkg
//  Purpose  : Shared types, constants and the texel pack helper for the
//             BC4/BC5 block decoder.
//  Contents : rgba5652_t  - 18-bit {R5,G6,B5,A2} texel
//             bc_pal_t    - 8 x 8-bit alpha-style palette
//             rgba5652_from_rg() - pack one or two channel values
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package texture_pkg;

    localparam int BC_ALPHA_BLOCK_BITS = 64;
    localparam int BC_TEXELS_PER_BLOCK = 16;
    localparam int BC_INDEX_BASE       = 16;

    typedef logic [17:0]     rgba5652_t;
    typedef logic [7:0][7:0] bc_pal_t;

    // Single channel replicates luminance into R/G/B; two channels map to R/G
    // with blue cleared. Alpha is always opaque.
    function automatic rgba5652_t rgba5652_from_rg(input logic [7:0] v0,
                                                   input logic [7:0] v1,
                                                   input logic       two_ch);
        if (two_ch) begin
            return {v0[7:3], v1[7:2], 5'b0, 2'b11};
        end
        return {v0[7:3], v0[7:2], v0[7:3], 2'b11};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bc_alpha_palette.sv
// ============================================================================
//  Module   : bc_alpha_palette
//  Purpose  : Combinational 8-entry palette generator for one BC4/BC5
//             channel from its two 8-bit endpoints.
//  Ports    : e0, e1 - unsigned endpoints
//             pal    - palette, pal[i] is the value for index i
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_alpha_palette
    import texture_pkg::*;
(
    input  logic [7:0] e0,
    input  logic [7:0] e1,
    output bc_pal_t    pal
);

    // Weighted sums reach 7*255+3, so the arithmetic is carried out at full
    // integer width and only the truncated quotient is kept.
    always_comb begin
        pal    = '0;
        pal[0] = e0;
        pal[1] = e1;
        if (e0 > e1) begin
            for (int i = 1; i <= 6; i++) begin
                pal[i+1] = 8'(((7 - i) * int'(e0) + i * int'(e1) + 3) / 7);
            end
        end else begin
            // Equal endpoints also land here.
            for (int i = 1; i <= 4; i++) begin
                pal[i+1] = 8'(((5 - i) * int'(e0) + i * int'(e1) + 2) / 5);
            end
            pal[6] = 8'h00;
            pal[7] = 8'hFF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/texture_bcx_block_decoder.sv
// ============================================================================
//  Module   : texture_bcx_block_decoder
//  Purpose  : Streaming BC4 (NUM_CH=1) / BC5 (NUM_CH=2) whole-block decoder.
//             Accepts one compressed 4x4 block and emits its 16 texels as
//             RGBA5652, TEXELS_PER_BEAT texels per beat.
//  Ports    : clk, rst_n          - clock, synchronous active-low reset
//             in_valid/in_ready   - block handshake, in_block payload
//             out_valid/out_ready - beat handshake
//             out_texels          - lane k = texel out_idx+k
//             out_idx             - row-major index of lane 0
//             out_last            - final beat of the block
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module texture_bcx_block_decoder
    import texture_pkg::*;
#(
    parameter int NUM_CH          = 1,
    parameter int TEXELS_PER_BEAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [64*NUM_CH-1:0]          in_block,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [18*TEXELS_PER_BEAT-1:0] out_texels,
    output logic [3:0]                    out_idx,
    output logic                          out_last
);

    if (!(NUM_CH == 1 || NUM_CH == 2)) begin : g_bad_num_ch
        $error("texture_bcx_block_decoder: NUM_CH must be 1 or 2");
    end
    if (!(TEXELS_PER_BEAT == 1 || TEXELS_PER_BEAT == 2 || TEXELS_PER_BEAT == 4 ||
          TEXELS_PER_BEAT == 8 || TEXELS_PER_BEAT == 16)) begin : g_bad_tpb
        $error("texture_bcx_block_decoder: TEXELS_PER_BEAT must be 1, 2, 4, 8 or 16");
    end

    localparam int         NUM_BEATS = BC_TEXELS_PER_BLOCK / TEXELS_PER_BEAT;
    localparam logic [3:0] LAST_BEAT = 4'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PAL  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            beat_q, beat_d;
    logic [64*NUM_CH-1:0]  block_q, block_d;
    bc_pal_t               pal_q [NUM_CH];
    bc_pal_t               pal_d [NUM_CH];
    bc_pal_t               pal_w [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pal
        bc_alpha_palette u_pal (
            .e0  (block_q[c*BC_ALPHA_BLOCK_BITS     +: 8]),
            .e1  (block_q[c*BC_ALPHA_BLOCK_BITS + 8 +: 8]),
            .pal (pal_w[c])
        );
    end

    // ------------------------------------------------------------------
    // Next-state / handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        block_d   = block_q;
        pal_d     = pal_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    block_d = in_block;
                    state_d = S_PAL;
                end
            end
            S_PAL: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    pal_d[c] = pal_w[c];
                end
                beat_d  = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_last  = (beat_q == LAST_BEAT);
                // A new block is only taken on the last-beat handshake so the
                // block register never changes under a beat still in flight.
                in_ready  = out_ready && out_last;
                if (out_ready) begin
                    if (out_last) begin
                        beat_d = '0;
                        if (in_valid) begin
                            block_d = in_block;
                            state_d = S_PAL;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // No block may be accepted while reset is asserted.
        in_ready = in_ready && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            block_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pal_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            block_q <= block_d;
            for (int c = 0; c < NUM_CH; c++) begin
                pal_q[c] <= pal_d[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-lane index extraction and palette lookup. Everything here is a
    // function of registered state, so the beat holds steady under stall.
    // ------------------------------------------------------------------
    always_comb begin
        logic [7:0] lane_v [2];
        logic [2:0] sel;
        int         t;
        out_texels = '0;
        lane_v[0]  = '0;
        lane_v[1]  = '0;
        sel        = '0;
        t          = 0;
        if (state_q == S_EMIT) begin
            for (int k = 0; k < TEXELS_PER_BEAT; k++) begin
                t = int'(beat_q) * TEXELS_PER_BEAT + k;
                for (int c = 0; c < NUM_CH; c++) begin
                    sel       = block_q[c*BC_ALPHA_BLOCK_BITS + BC_INDEX_BASE + 3*t +: 3];
                    lane_v[c] = pal_q[c][sel];
                end
                out_texels[k*18 +: 18] = rgba5652_from_rg(lane_v[0], lane_v[1], NUM_CH == 2);
            end
        end
    end

    assign out_idx = 4'(int'(beat_q) * TEXELS_PER_BEAT);

endmodule

`default_nettype wire

// File: tb/tb_texture_bcx_block_decoder.sv
// ============================================================================
//  Module   : tb_texture_bcx_block_decoder
//  Purpose  : Self-checking bench for texture_bcx_block_decoder. DUT A is
//             BC4 with one texel per beat, DUT B is BC5 with four per beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_texture_bcx_block_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [63:0] a_in_block;
    logic [17:0] a_out_texels;
    logic [3:0]  a_out_idx;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [127:0] b_in_block;
    logic [71:0] b_out_texels;
    logic [3:0]  b_out_idx;

    texture_bcx_block_decoder #(.NUM_CH(1), .TEXELS_PER_BEAT(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_block(a_in_block),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_texels(a_out_texels),
        .out_idx(a_out_idx), .out_last(a_out_last)
    );

    texture_bcx_block_decoder #(.NUM_CH(2), .TEXELS_PER_BEAT(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_block(b_in_block),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_texels(b_out_texels),
        .out_idx(b_out_idx), .out_last(b_out_last)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0]  blk;
        logic [287:0] exp;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference for a single BC4 texel.
    function automatic logic [7:0] m_pal(input logic [7:0] e0, input logic [7:0] e1, input int i);
        int a, b;
        a = int'(e0);
        b = int'(e1);
        if (i == 0) return e0;
        if (i == 1) return e1;
        if (a > b) return 8'(((8 - i) * a + (i - 1) * b + 3) / 7);
        if (i == 6) return 8'h00;
        if (i == 7) return 8'hFF;
        return 8'(((6 - i) * a + (i - 1) * b + 2) / 5);
    endfunction

    function automatic logic [17:0] pack1(input logic [7:0] v);
        return {v[7:3], v[7:2], v[7:3], 2'b11};
    endfunction

    function automatic logic [17:0] m_texel(input logic [63:0] blk, input int t);
        logic [2:0] ix;
        ix = blk[16 + 3*t +: 3];
        return pack1(m_pal(blk[7:0], blk[15:8], int'(ix)));
    endfunction

    function automatic logic [63:0] mk_blk(input logic [7:0] e0, input logic [7:0] e1, input logic [2:0] ix);
        logic [63:0] b;
        b = {48'h0, e1, e0};
        for (int t = 0; t < 16; t++) b[16 + 3*t +: 3] = ix;
        return b;
    endfunction

    function automatic logic [287:0] rep16(input logic [17:0] v);
        return {16{v}};
    endfunction

    // Present a block on DUT A and wait (bounded) for its handshake edge.
    task automatic send_a(input logic [63:0] blk, input string name);
        int n;
        bit hs;
        n  = 0;
        hs = 1'b0;
        a_in_block = blk;
        a_in_valid = 1'b1;
        #1;
        while (!hs && n < 40) begin
            hs = a_in_ready;
            tick();
            n++;
        end
        a_in_valid = 1'b0;
        chk({name, "_accept"}, 128'(hs), 128'd1);
    endtask

    task automatic run_vec(input int vi);
        a_out_ready = 1'b1;
        send_a(vecs[vi].blk, $sformatf("vec%0d", vi));
        chk($sformatf("vec%0d_pal_cycle_valid", vi), 128'(a_out_valid), 128'd0);
        tick();
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("vec%0d_valid%0d", vi, b), 128'(a_out_valid), 128'd1);
            chk($sformatf("vec%0d_texel%0d", vi, b), 128'(a_out_texels), 128'(vecs[vi].exp[b*18 +: 18]));
            chk($sformatf("vec%0d_idx%0d", vi, b), 128'(a_out_idx), 128'(b));
            chk($sformatf("vec%0d_last%0d", vi, b), 128'(a_out_last), 128'(b == 15));
            tick();
        end
        chk($sformatf("vec%0d_idle_after", vi), 128'(a_out_valid), 128'd0);
    endtask

    // Three blocks offered back-to-back, with optional random output stalls.
    task automatic back_to_back(input bit rnd);
        logic [63:0] blks [3];
        logic [17:0] q [$];
        logic [17:0] h_tex, e_tex;
        logic [3:0]  h_idx;
        logic        h_last;
        int bi, got, cyc, last0_cyc, first1_cyc;
        bit stall_prev;
        bi = 0; got = 0; cyc = 0; last0_cyc = -100; first1_cyc = 0;
        stall_prev = 1'b0; h_tex = '0; h_idx = '0; h_last = 1'b0;
        for (int k = 0; k < 3; k++) blks[k] = {$urandom(), $urandom()};
        blks[0][15:0] = 16'h1AE5;   // e0 > e1: 8-entry mode
        blks[1][15:0] = 16'hD022;   // e0 < e1: 6-entry mode
        while (got < 48 && cyc < 600) begin
            a_in_valid  = (bi < 3);
            a_in_block  = blks[(bi < 3) ? bi : 2];
            a_out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (stall_prev) begin
                chk("bb_hold_valid", 128'(a_out_valid), 128'd1);
                chk("bb_hold_texel", 128'(a_out_texels), 128'(h_tex));
                chk("bb_hold_idx", 128'(a_out_idx), 128'(h_idx));
                chk("bb_hold_last", 128'(a_out_last), 128'(h_last));
            end
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) begin
                    chk("bb_extra_beat", 128'(got), 128'd99999);
                    e_tex = '0;
                end else begin
                    e_tex = q.pop_front();
                end
                chk($sformatf("bb_texel%0d", got), 128'(a_out_texels), 128'(e_tex));
                chk($sformatf("bb_idx%0d", got), 128'(a_out_idx), 128'(got % 16));
                chk($sformatf("bb_last%0d", got), 128'(a_out_last), 128'((got % 16) == 15));
                if (got == 15) last0_cyc = cyc;
                if (got == 16) first1_cyc = cyc;
                got++;
            end
            stall_prev = a_out_valid && !a_out_ready;
            h_tex  = a_out_texels;
            h_idx  = a_out_idx;
            h_last = a_out_last;
            if (a_in_valid && a_in_ready) begin
                for (int t = 0; t < 16; t++) q.push_back(m_texel(blks[bi], t));
                bi++;
            end
            tick();
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        chk("bb_beat_count", 128'(got), 128'd48);
        chk("bb_queue_empty", 128'(q.size()), 128'd0);
        if (!rnd) chk("bb_gap_cycles", 128'(first1_cyc - last0_cyc), 128'd2);
        #1;
        chk("bb_idle_after", 128'(a_out_valid), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] h;
        logic [63:0] sblk;
        bit found;
        int stray;

        // Stimulus table
        vecs[0].blk = mk_blk(8'hFF, 8'h00, 3'd2);
        vecs[0].exp = rep16({5'h1B, 6'h36, 5'h1B, 2'b11});
        vecs[1].blk = mk_blk(8'h00, 8'hFF, 3'd0);
        vecs[1].blk[18:16] = 3'd6;
        vecs[1].blk[21:19] = 3'd7;
        vecs[1].exp = rep16(18'h00003);
        vecs[1].exp[35:18] = 18'h3FFFF;
        vecs[2].blk = mk_blk(8'h80, 8'h80, 3'd0);
        vecs[2].exp = rep16({5'h10, 6'h20, 5'h10, 2'b11});
        vecs[3].blk = mk_blk(8'h00, 8'hFF, 3'd2);       // (0+255+2)/5 = 51
        vecs[3].exp = rep16({5'h06, 6'h0C, 5'h06, 2'b11});
        vecs[4].blk = mk_blk(8'hFF, 8'h00, 3'd7);       // (255+3)/7 = 36
        vecs[4].exp = rep16({5'h04, 6'h09, 5'h04, 2'b11});
        vecs[5].blk = mk_blk(8'h20, 8'h10, 3'd1);       // p1 = e1 = 0x10
        vecs[5].exp = rep16({5'h02, 6'h04, 5'h02, 2'b11});
        vecs[6].blk = mk_blk(8'h40, 8'h40, 3'd7);       // equal endpoints: p7 = 255
        vecs[6].exp = rep16(18'h3FFFF);

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_block = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_block = '0; b_out_ready = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_a_out_valid", 128'(a_out_valid), 128'd0);
        chk("rst_a_in_ready", 128'(a_in_ready), 128'd0);
        chk("rst_a_out_idx", 128'(a_out_idx), 128'd0);
        chk("rst_a_out_last", 128'(a_out_last), 128'd0);
        chk("rst_a_out_texels", 128'(a_out_texels), 128'd0);
        chk("rst_b_out_valid", 128'(b_out_valid), 128'd0);
        chk("rst_b_out_texels", 128'(b_out_texels), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_a_in_ready", 128'(a_in_ready), 128'd1);
        chk("idle_b_in_ready", 128'(b_in_ready), 128'd1);

        // Table-driven single-block vectors
        for (int vi = 0; vi < NVEC; vi++) run_vec(vi);

        // BC5 wide beat
        b_out_ready = 1'b1;
        b_in_block  = {48'h0, 8'h40, 8'h40, 48'h0, 8'h80, 8'h80};
        b_in_valid  = 1'b1;
        #1;
        chk("bc5_accept", 128'(b_in_ready), 128'd1);
        tick();
        b_in_valid = 1'b0;
        chk("bc5_pal_valid", 128'(b_out_valid), 128'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("bc5_valid%0d", b), 128'(b_out_valid), 128'd1);
            chk($sformatf("bc5_texels%0d", b), 128'(b_out_texels), 128'({4{5'h10, 6'h10, 5'h00, 2'b11}}));
            chk($sformatf("bc5_idx%0d", b), 128'(b_out_idx), 128'(b * 4));
            chk($sformatf("bc5_last%0d", b), 128'(b_out_last), 128'(b == 3));
            tick();
        end
        chk("bc5_idle_after", 128'(b_out_valid), 128'd0);

        // Back-to-back, full rate then random stalls
        back_to_back(1'b0);
        back_to_back(1'b1);

        // Reset in the middle of a block
        a_out_ready = 1'b1;
        send_a(vecs[0].blk, "rstmid");
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (a_out_valid && a_out_idx == 4'd5) found = 1'b1;
            else tick();
        end
        chk("rstmid_reach_beat5", 128'(found), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_in_ready_low", 128'(a_in_ready), 128'd0);
        tick();
        chk("rstmid_out_valid", 128'(a_out_valid), 128'd0);
        chk("rstmid_in_ready", 128'(a_in_ready), 128'd0);
        chk("rstmid_out_idx", 128'(a_out_idx), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rstmid_release_in_ready", 128'(a_in_ready), 128'd1);
        stray = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (a_out_valid) stray++;
        end
        chk("rstmid_no_stale_beats", 128'(stray), 128'd0);
        run_vec(2);

        // Stall hold at beat 3
        sblk = 64'hFAC6_88D1_5E37_30E0;
        a_out_ready = 1'b1;
        send_a(sblk, "stall");
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (a_out_valid && a_out_idx == 4'd3) found = 1'b1;
            else tick();
        end
        chk("stall_reach_beat3", 128'(found), 128'd1);
        a_out_ready = 1'b0;
        #1;
        h = a_out_texels;
        chk("stall_texel3", 128'(h), 128'(m_texel(sblk, 3)));
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("stall_valid", 128'(a_out_valid), 128'd1);
            chk("stall_texel", 128'(a_out_texels), 128'(h));
            chk("stall_idx", 128'(a_out_idx), 128'd3);
            chk("stall_last", 128'(a_out_last), 128'd0);
            chk("stall_in_ready", 128'(a_in_ready), 128'd0);
        end
        a_out_ready = 1'b1;
        #1;
        for (int b = 3; b < 16; b++) begin
            chk($sformatf("stall_drain_idx%0d", b), 128'(a_out_idx), 128'(b));
            chk($sformatf("stall_drain_texel%0d", b), 128'(a_out_texels), 128'(m_texel(sblk, b)));
            tick();
        end
        chk("stall_idle_after", 128'(a_out_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
